// File: rtl/rf_issue_sequencer.sv
// In-order issue controller for the polynomial register file: RAW/WAW scoreboard,
// start-pulse generation and an in-order FIFO of destinations awaiting writeback.
module rf_issue_sequencer #(
  parameter int NREG            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OPW             = 4,
  localparam int IW             = $clog2(NREG),
  localparam int PW             = $clog2(MAX_OUTSTANDING),
  localparam int CW             = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_opcode,
  input  logic [IW-1:0]  instr_src0,
  input  logic [IW-1:0]  instr_src1,
  input  logic [IW-1:0]  instr_dst,
  input  logic           instr_use_src1,
  input  logic           rf_ready,
  output logic           rf_start_operation,
  output logic [IW-1:0]  rf_source0_register_index,
  output logic [IW-1:0]  rf_source1_register_index,
  output logic           rf_use_source1,
  output logic [IW-1:0]  rf_destination_register_index,
  input  logic           rf_source0_last,
  input  logic           rf_destination_valid,
  input  logic           rf_destination_last,
  output logic           fu_start,
  output logic [OPW-1:0] fu_opcode,
  output logic [CW-1:0]  outstanding_count,
  output logic           busy,
  output logic           wb_error
);

  localparam logic [1:0] ST_WAIT_RF = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_STREAM  = 2'd2;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [NREG-1:0] busy_bits_r;
  logic [NREG-1:0] busy_bits_nxt_s;
  logic [IW-1:0]   fifo_r [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            start_r;
  logic [IW-1:0]   src0_r;
  logic [IW-1:0]   src1_r;
  logic            use_src1_r;
  logic [OPW-1:0]  opcode_r;
  logic            wb_error_r;

  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            pop_s;
  logic            stray_s;
  logic            slot_ok_s;
  logic            hazard_free_s;
  logic            ready_s;
  logic            issue_s;

  assign fifo_empty_s = (count_r == CW'(0));
  assign fifo_full_s  = (count_r == CW'(MAX_OUTSTANDING));
  assign pop_s        = rf_destination_valid && rf_destination_last && !fifo_empty_s;
  assign stray_s      = (rf_destination_valid || rf_destination_last) && fifo_empty_s;

  // Issue gating: hazards read the scoreboard as it stood at the start of the cycle.
  always_comb begin
    slot_ok_s     = (state_r == ST_IDLE) || ((state_r == ST_STREAM) && rf_source0_last);
    hazard_free_s = !busy_bits_r[instr_src0]
                    && (!instr_use_src1 || !busy_bits_r[instr_src1])
                    && !busy_bits_r[instr_dst];
    ready_s       = slot_ok_s && (!fifo_full_s || pop_s) && hazard_free_s;
    issue_s       = instr_valid && ready_s;
  end

  // Sequencer state: stay in STREAM across a zero-bubble back-to-back issue.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT_RF: begin
        if (rf_ready) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_WAIT_RF;
      end
      ST_IDLE: begin
        if (issue_s)        state_nxt_s = ST_STREAM;
        else if (!rf_ready) state_nxt_s = ST_WAIT_RF;
        else                state_nxt_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (!rf_source0_last) state_nxt_s = ST_STREAM;
        else if (issue_s)     state_nxt_s = ST_STREAM;
        else if (!rf_ready)   state_nxt_s = ST_WAIT_RF;
        else                  state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_WAIT_RF;
    endcase
  end

  // Scoreboard update: the issue's set is applied after the retire's clear so it wins.
  always_comb begin
    busy_bits_nxt_s = busy_bits_r;
    if (pop_s) busy_bits_nxt_s[fifo_r[rd_ptr_r]] = 1'b0;
    else       busy_bits_nxt_s = busy_bits_r;
    if (issue_s) busy_bits_nxt_s[instr_dst] = 1'b1;
    else         busy_bits_nxt_s = busy_bits_nxt_s;
  end

  // State, scoreboard and destination FIFO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_WAIT_RF;
      busy_bits_r <= {NREG{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_r[i] <= {IW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      busy_bits_r <= busy_bits_nxt_s;
      if (issue_s) begin
        fifo_r[wr_ptr_r] <= instr_dst;
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      else       rd_ptr_r <= rd_ptr_r;
      case ({issue_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered issue outputs; indices and opcode hold until the next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_r    <= 1'b0;
      src0_r     <= {IW{1'b0}};
      src1_r     <= {IW{1'b0}};
      use_src1_r <= 1'b0;
      opcode_r   <= {OPW{1'b0}};
      wb_error_r <= 1'b0;
    end else begin
      start_r <= issue_s;
      if (issue_s) begin
        src0_r     <= instr_src0;
        src1_r     <= instr_src1;
        use_src1_r <= instr_use_src1;
        opcode_r   <= instr_opcode;
      end else begin
        src0_r     <= src0_r;
        src1_r     <= src1_r;
        use_src1_r <= use_src1_r;
        opcode_r   <= opcode_r;
      end
      wb_error_r <= wb_error_r || stray_s;
    end
  end

  assign instr_ready                   = ready_s;
  assign rf_start_operation            = start_r;
  assign fu_start                      = start_r;
  assign rf_source0_register_index     = src0_r;
  assign rf_source1_register_index     = src1_r;
  assign rf_use_source1                = use_src1_r;
  assign fu_opcode                     = opcode_r;
  assign rf_destination_register_index = fifo_empty_s ? {IW{1'b0}} : fifo_r[rd_ptr_r];
  assign outstanding_count             = count_r;
  assign busy                          = (state_r == ST_STREAM) || !fifo_empty_s;
  assign wb_error                      = wb_error_r;

endmodule

// File: tb/tb_rf_issue_sequencer.sv
// Directed bench for rf_issue_sequencer: issue, hazards, back-to-back, FIFO full, stray beats, reset.
module tb_rf_issue_sequencer;
  localparam int IW  = 5;
  localparam int OPW = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] instr_opcode;
  logic [IW-1:0]  instr_src0;
  logic [IW-1:0]  instr_src1;
  logic [IW-1:0]  instr_dst;
  logic           instr_use_src1;
  logic           rf_ready;
  logic           rf_start_operation;
  logic [IW-1:0]  rf_source0_register_index;
  logic [IW-1:0]  rf_source1_register_index;
  logic           rf_use_source1;
  logic [IW-1:0]  rf_destination_register_index;
  logic           rf_source0_last;
  logic           rf_destination_valid;
  logic           rf_destination_last;
  logic           fu_start;
  logic [OPW-1:0] fu_opcode;
  logic [CW-1:0]  outstanding_count;
  logic           busy;
  logic           wb_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_issue_sequencer #(.NREG(32), .MAX_OUTSTANDING(4), .OPW(4)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_src0(instr_src0), .instr_src1(instr_src1),
    .instr_dst(instr_dst), .instr_use_src1(instr_use_src1),
    .rf_ready(rf_ready), .rf_start_operation(rf_start_operation),
    .rf_source0_register_index(rf_source0_register_index),
    .rf_source1_register_index(rf_source1_register_index),
    .rf_use_source1(rf_use_source1),
    .rf_destination_register_index(rf_destination_register_index),
    .rf_source0_last(rf_source0_last), .rf_destination_valid(rf_destination_valid),
    .rf_destination_last(rf_destination_last), .fu_start(fu_start), .fu_opcode(fu_opcode),
    .outstanding_count(outstanding_count), .busy(busy), .wb_error(wb_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [3:0] op, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] d, input logic u);
    instr_valid    = 1'b1;
    instr_opcode   = op;
    instr_src0     = s0;
    instr_src1     = s1;
    instr_dst      = d;
    instr_use_src1 = u;
  endtask

  initial begin
    logic [4:0] order [4];
    order[0] = 5'd4; order[1] = 5'd7; order[2] = 5'd8; order[3] = 5'd9;

    reset = 1'b1; instr_valid = 1'b0; instr_opcode = 4'd0; instr_src0 = 5'd0;
    instr_src1 = 5'd0; instr_dst = 5'd0; instr_use_src1 = 1'b0; rf_ready = 1'b0;
    rf_source0_last = 1'b0; rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_start", 32'(rf_start_operation), 32'd0);
    chk("rst_count", 32'(outstanding_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wberr", 32'(wb_error), 32'd0);
    chk("rst_dstidx", 32'(rf_destination_register_index), 32'd0);

    // Basic issue and writeback
    reset = 1'b0; rf_ready = 1'b1;
    tick();
    chk("t1_state_idle", 32'(dut.state_r), 32'd1);
    offer(4'd5, 5'd1, 5'd2, 5'd3, 1'b1);
    #1 chk("t1_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("t1_start", 32'(rf_start_operation), 32'd1);
    chk("t1_fustart", 32'(fu_start), 32'd1);
    chk("t1_src0", 32'(rf_source0_register_index), 32'd1);
    chk("t1_src1", 32'(rf_source1_register_index), 32'd2);
    chk("t1_use1", 32'(rf_use_source1), 32'd1);
    chk("t1_opcode", 32'(fu_opcode), 32'd5);
    chk("t1_dstidx", 32'(rf_destination_register_index), 32'd3);
    chk("t1_busybit3", 32'(dut.busy_bits_r[3]), 32'd1);
    chk("t1_count", 32'(outstanding_count), 32'd1);
    tick();
    chk("t1_start_pulse", 32'(rf_start_operation), 32'd0);
    rf_source0_last = 1'b1;
    tick();
    rf_source0_last = 1'b0;
    chk("t1_state_back", 32'(dut.state_r), 32'd1);
    rf_destination_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_dst_stable", 32'(rf_destination_register_index), 32'd3);
    end
    rf_destination_last = 1'b1;
    tick();
    rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    chk("t1_count_done", 32'(outstanding_count), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_busybit3_clr", 32'(dut.busy_bits_r[3]), 32'd0);
    chk("t1_dstidx_empty", 32'(rf_destination_register_index), 32'd0);

    // RAW hazard on register 5
    offer(4'd3, 5'd0, 5'd0, 5'd5, 1'b0);
    tick();
    instr_valid = 1'b0;
    chk("raw_first_start", 32'(rf_start_operation), 32'd1);
    rf_source0_last = 1'b1;
    tick();
    rf_source0_last = 1'b0;
    offer(4'd2, 5'd5, 5'd0, 5'd6, 1'b0);
    #1 chk("raw_blocked0", 32'(instr_ready), 32'd0);
    tick();
    chk("raw_blocked1", 32'(instr_ready), 32'd0);
    rf_destination_valid = 1'b1; rf_destination_last = 1'b1;
    #1 chk("raw_blocked_retire", 32'(instr_ready), 32'd0);
    tick();
    rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    #1 chk("raw_ready_after", 32'(instr_ready), 32'd1);
    chk("raw_no_start_yet", 32'(rf_start_operation), 32'd0);
    tick();
    instr_valid = 1'b0;
    chk("raw_start", 32'(rf_start_operation), 32'd1);
    chk("raw_src0", 32'(rf_source0_register_index), 32'd5);
    chk("raw_dstidx", 32'(rf_destination_register_index), 32'd6);
    chk("raw_count", 32'(outstanding_count), 32'd1);
    rf_source0_last = 1'b1;
    tick();
    rf_source0_last = 1'b0;
    rf_destination_valid = 1'b1; rf_destination_last = 1'b1;
    tick();
    rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    chk("raw_count_done", 32'(outstanding_count), 32'd0);

    // Back-to-back independent ops
    offer(4'd1, 5'd2, 5'd0, 5'd1, 1'b0);
    #1 chk("b2b_ready0", 32'(instr_ready), 32'd1);
    tick();
    chk("b2b_start0", 32'(rf_start_operation), 32'd1);
    offer(4'd7, 5'd6, 5'd0, 5'd4, 1'b0);
    rf_source0_last = 1'b1;
    #1 chk("b2b_ready1", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_start1", 32'(rf_start_operation), 32'd1);
    chk("b2b_src0", 32'(rf_source0_register_index), 32'd6);
    chk("b2b_opcode", 32'(fu_opcode), 32'd7);
    chk("b2b_state", 32'(dut.state_r), 32'd2);
    chk("b2b_count", 32'(outstanding_count), 32'd2);
    chk("b2b_head", 32'(rf_destination_register_index), 32'd1);
    tick();
    rf_source0_last = 1'b0;
    chk("b2b_idle", 32'(dut.state_r), 32'd1);
    chk("b2b_start_low", 32'(rf_start_operation), 32'd0);

    // Fill the FIFO, then retire and issue in the same cycle
    offer(4'd0, 5'd0, 5'd0, 5'd7, 1'b0);
    tick();
    offer(4'd0, 5'd0, 5'd0, 5'd8, 1'b0);
    rf_source0_last = 1'b1;
    tick();
    offer(4'd0, 5'd0, 5'd0, 5'd9, 1'b0);
    #1 chk("full_ready_stream", 32'(instr_ready), 32'd0);
    chk("full_count", 32'(outstanding_count), 32'd4);
    tick();
    rf_source0_last = 1'b0;
    #1 chk("full_ready_idle", 32'(instr_ready), 32'd0);
    rf_destination_valid = 1'b1; rf_destination_last = 1'b1;
    #1 chk("full_ready_pop", 32'(instr_ready), 32'd1);
    chk("full_head", 32'(rf_destination_register_index), 32'd1);
    tick();
    instr_valid = 1'b0; rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    chk("swap_count", 32'(outstanding_count), 32'd4);
    chk("swap_start", 32'(rf_start_operation), 32'd1);
    chk("swap_head", 32'(rf_destination_register_index), 32'd4);
    chk("swap_bit1", 32'(dut.busy_bits_r[1]), 32'd0);
    chk("swap_bit9", 32'(dut.busy_bits_r[9]), 32'd1);
    rf_source0_last = 1'b1;
    tick();
    rf_source0_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("order_head", 32'(rf_destination_register_index), 32'(order[i]));
      rf_destination_valid = 1'b1; rf_destination_last = 1'b1;
      tick();
      rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    end
    chk("drain_count", 32'(outstanding_count), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // Stray writeback beat with an empty FIFO
    rf_destination_valid = 1'b1; rf_destination_last = 1'b1;
    tick();
    rf_destination_valid = 1'b0; rf_destination_last = 1'b0;
    chk("stray_err", 32'(wb_error), 32'd1);
    chk("stray_count", 32'(outstanding_count), 32'd0);
    tick();
    chk("stray_sticky", 32'(wb_error), 32'd1);
    chk("stray_bits", dut.busy_bits_r, 32'd0);

    // Reset mid-stream with two outstanding
    offer(4'd0, 5'd0, 5'd0, 5'd10, 1'b0);
    tick();
    offer(4'd0, 5'd0, 5'd0, 5'd11, 1'b0);
    rf_source0_last = 1'b1;
    tick();
    instr_valid = 1'b0; rf_source0_last = 1'b0;
    chk("pre_rst_count", 32'(outstanding_count), 32'd2);
    reset = 1'b1;
    tick();
    chk("mrst_start", 32'(rf_start_operation), 32'd0);
    chk("mrst_src0", 32'(rf_source0_register_index), 32'd0);
    chk("mrst_opcode", 32'(fu_opcode), 32'd0);
    chk("mrst_dstidx", 32'(rf_destination_register_index), 32'd0);
    chk("mrst_count", 32'(outstanding_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_wberr", 32'(wb_error), 32'd0);
    chk("mrst_state", 32'(dut.state_r), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", 32'(dut.state_r), 32'd1);
    offer(4'd9, 5'd3, 5'd4, 5'd12, 1'b1);
    #1 chk("post_rst_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("post_rst_start", 32'(rf_start_operation), 32'd1);
    chk("post_rst_dstidx", 32'(rf_destination_register_index), 32'd12);
    chk("post_rst_src1", 32'(rf_source1_register_index), 32'd4);
    chk("post_rst_opcode", 32'(fu_opcode), 32'd9);
    chk("post_rst_count", 32'(outstanding_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
